nibble_serializer: RTL and testbench
====================================

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, byte FIFO entries (power of two, >=2).
REQ-002 The module SHALL have parameter CNT_W, default 8, width of the emitted-byte counter.
REQ-003 The module SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port in_data  input  8 (uint8_t)  byte to serialize.
REQ-006 The module SHALL have port in_valid  input  1  in_data is valid.
REQ-007 The module SHALL have port in_ready  output  1  FIFO can accept a byte.
REQ-008 The module SHALL have port out_nib  output  4 (uint4_t)  current nibble.
REQ-009 The module SHALL have port out_valid  output  1  out_nib is valid.
REQ-010 The module SHALL have port out_ready  input  1  consumer takes out_nib.
REQ-011 The module SHALL have port out_last  output  1  out_nib is the high (second) nibble of its byte.
REQ-012 The module SHALL have port byte_cnt  output  CNT_W  count of bytes fully emitted.

Function
REQ-013 Push SHALL occur on in_valid && in_ready; pop of a byte from the FIFO SHALL occur when the serializer loads it.
REQ-014 in_ready SHALL equal !full, with no dependence on out_ready (no same-cycle pass-through when full).
REQ-015 The serializer FSM SHALL have states IDLE, LO, HI.
- IDLE: if FIFO non-empty, load head byte into hold register and go to LO.
- LO: out_nib = hold[3:0], out_last=0; on out_ready go to HI.
- HI: out_nib = hold[7:4], out_last=1; on out_ready, byte_cnt++, then load next byte and go to LO if FIFO non-empty, else go to IDLE.
REQ-016 out_valid SHALL be 1 exactly in LO and HI; out_nib and out_last SHALL be stable while out_valid && !out_ready.
REQ-017 Latency: a byte pushed into an empty FIFO with the FSM in IDLE in cycle N SHALL show its low nibble with out_valid=1 in cycle N+2.
REQ-018 With out_ready held high and the FIFO never empty, throughput SHALL be one nibble per cycle with no bubbles between bytes.
REQ-019 Simultaneous push and pop SHALL leave the occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-020 byte_cnt SHALL wrap from 2^CNT_W-1 to 0 without saturating.
REQ-021 Bytes SHALL be emitted in push order with none dropped or duplicated; pushes while full SHALL be impossible (in_ready=0).

Reset
REQ-022 Asserting rst SHALL immediately force IDLE, an empty FIFO, in_ready=1 (after release), out_valid=0, out_last=0, out_nib=0, byte_cnt=0.
REQ-023 Reset mid-byte SHALL discard the held byte and all FIFO contents; no partial nibble SHALL appear after release.

Configuration
REQ-024 Macro NIBBLE_SER_MSB_FIRST_EN defined: LO/HI SHALL emit hold[7:4] first and hold[3:0] second (out_last still marks the second nibble).
REQ-025 Macro NIBBLE_SER_MSB_FIRST_EN undefined: the order SHALL be low nibble first as in REQ-015.

Structure
REQ-026 Package nibble_pkg SHALL hold typedefs uint4_t (logic [3:0]), uint8_t (logic [7:0]), and enum ser_state_t {IDLE, LO, HI}.
REQ-027 The byte FIFO SHALL be a sub-module nibble_fifo (DEPTH, uint8_t entries, push/pop/full/empty).
REQ-028 No module-local typedef SHALL shadow a nibble_pkg type name.

Verification
REQ-029 Single byte: push 8'hA5 with out_ready=1 -> out_nib 4'h5 (last=0) then 4'hA (last=1), byte_cnt=1 (MSB_FIRST_EN: 4'hA then 4'h5).
REQ-030 Back-to-back: push 8'h12, 8'h34, 8'h56 with out_ready=1 -> nibbles 2,1,4,3,6,5 on consecutive cycles, byte_cnt=3.
REQ-031 Backpressure: out_ready=0, push DEPTH+1 bytes -> in_ready=0 after the FIFO fills, out_nib held at the first byte's low nibble; release -> all bytes in order.
REQ-032 Wrap: CNT_W=2, emit 5 bytes -> byte_cnt sequence 1,2,3,0,1.
REQ-033 Reset mid-byte: push 8'h5A, assert rst while out_nib=4'hA -> out_valid=0, byte_cnt=0; after release, idle until a new push.
REQ-034 Simultaneous: FIFO half full, push and pop in the same cycle -> occupancy unchanged, order preserved.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared types and nibble-ordering helpers for the nibble serializer.
// Optional build macro NIBBLE_SER_MSB_FIRST_EN: emit the high nibble of each byte first.
package nibble_pkg;

  typedef logic [3:0] uint4_t;
  typedef logic [7:0] uint8_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } ser_state_t;

  // Nibble shown while in LO (first half of a byte on the wire)
  function automatic uint4_t first_nib(uint8_t b);
`ifdef NIBBLE_SER_MSB_FIRST_EN
    return b[7:4];
`else
    return b[3:0];
`endif
  endfunction

  // Nibble shown while in HI (second half, flagged by out_last)
  function automatic uint4_t second_nib(uint8_t b);
`ifdef NIBBLE_SER_MSB_FIRST_EN
    return b[3:0];
`else
    return b[7:4];
`endif
  endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Byte FIFO feeding the serializer; full/empty flags are registered.
module nibble_fifo
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  uint8_t wr_data_i,
  input  logic   pop_i,
  output uint8_t rd_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic [OCC_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;
  uint8_t           mem_q [DEPTH];

  assign push_ok   = push_i && !full_q;
  assign pop_ok    = pop_i && !empty_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

  // Occupancy update; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == OCC_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array, no reset needed since empty_q gates reads
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/nibble_serializer.sv
// Byte-to-nibble serializer: byte FIFO followed by an IDLE/LO/HI emitter FSM.
// Optional build macro NIBBLE_SER_MSB_FIRST_EN selects high-nibble-first order.
module nibble_serializer
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  uint8_t           in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output uint4_t           out_nib,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] byte_cnt
);

  ser_state_t       state_q;
  uint8_t           hold_q;
  uint4_t           out_nib_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [CNT_W-1:0] byte_cnt_q;

  logic   fifo_full;
  logic   fifo_empty;
  uint8_t fifo_head;
  logic   push_c;
  logic   pop_c;

  // Accept only while the FIFO has room; never depends on out_ready
  assign in_ready = !fifo_full;
  assign push_c   = in_valid && !fifo_full;
  // A byte leaves the FIFO exactly when the FSM loads it into hold_q
  assign pop_c    = !fifo_empty && ((state_q == IDLE) || ((state_q == HI) && out_ready));

  nibble_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_c),
    .wr_data_i (in_data),
    .pop_i     (pop_c),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Emitter FSM with registered nibble, valid, last and byte counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      out_nib_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            hold_q      <= fifo_head;
            out_nib_q   <= first_nib(fifo_head);
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            state_q     <= LO;
          end
        end
        LO: begin
          if (out_ready) begin
            out_nib_q  <= second_nib(hold_q);
            out_last_q <= 1'b1;
            state_q    <= HI;
          end
        end
        HI: begin
          if (out_ready) begin
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            if (!fifo_empty) begin
              // Chain straight into the next byte so there is no bubble
              hold_q      <= fifo_head;
              out_nib_q   <= first_nib(fifo_head);
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              state_q     <= LO;
            end else begin
              out_nib_q   <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= IDLE;
            end
          end
        end
        default: begin
          out_nib_q   <= '0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_nib   = out_nib_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: per-cycle vector table plus corner sequences.
// Honours NIBBLE_SER_MSB_FIRST_EN for the expected nibble order.
module tb_nibble_serializer;
  import nibble_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic   clk = 1'b0;
  logic   rst;
  uint8_t in_data;
  logic   in_valid;
  logic   out_ready;

  logic       in_ready,  in_ready_w;
  uint4_t     out_nib,   out_nib_w;
  logic       out_valid, out_valid_w;
  logic       out_last,  out_last_w;
  logic [7:0] byte_cnt;
  logic [1:0] byte_cnt_w;

  int checks = 0;
  int errors = 0;

  uint8_t exp_bytes[$];

  always #5 clk = ~clk;

  nibble_serializer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_nib(out_nib), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .byte_cnt(byte_cnt)
  );

  nibble_serializer #(.DEPTH(DEPTH), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w), .out_nib(out_nib_w), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_last(out_last_w), .byte_cnt(byte_cnt_w)
  );

  typedef struct {
    logic   iv;
    uint8_t data;
    logic   ordy;
    logic   e_valid;
    uint8_t e_byte;
    logic   e_last;
    logic   e_in_ready;
    int     e_cnt;
  } vec_t;

  vec_t vecs[12];

  // Expected nibble of a byte, independent of the RTL helpers
  function automatic uint4_t nib_of(uint8_t b, logic second);
`ifdef NIBBLE_SER_MSB_FIRST_EN
    return second ? b[3:0] : b[7:4];
`else
    return second ? b[7:4] : b[3:0];
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Consume exp_bytes with out_ready high, starting from the currently shown nibble
  task automatic drain(input string nm);
    int k;
    int total;
    k = 0;
    total = exp_bytes.size() * 2;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && k < total; cyc++) begin
      if (out_valid) begin
        chk({nm, "_nib"}, 32'({out_last, out_nib}),
            32'({1'(k % 2), nib_of(exp_bytes[k / 2], 1'(k % 2))}));
        k++;
      end
      step();
    end
    chk({nm, "_count"}, 32'(k), 32'(total));
  endtask

  initial begin
    int n_cnt;
    logic [1:0] prev_w;
    logic [1:0] wrap_exp [5];
    uint8_t bp [6];

    // Single byte then back-to-back bytes, one row per clock edge
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1};
    vecs[4]  = '{1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1};
    vecs[5]  = '{1'b1, 8'h34, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b1, 8'h56, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 2};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h34, 1'b1, 1'b1, 2};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b0, 1'b1, 3};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h56, 1'b1, 1'b1, 3};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4};

    // Reset state, checked while reset is held
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_last", 32'(out_last), 32'(0));
    chk("rst_nib", 32'(out_nib), 32'(0));
    chk("rst_cnt", 32'(byte_cnt), 32'(0));
    chk("rst_w_valid", 32'({out_valid_w, out_last_w, out_nib_w}), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rst_in_ready", 32'({in_ready, in_ready_w}), 32'(2'b11));

    // Table-driven section
    for (int i = 0; i < 12; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_nib", i), 32'(out_nib),
          vecs[i].e_valid ? 32'(nib_of(vecs[i].e_byte, vecs[i].e_last)) : 32'(0));
      chk($sformatf("v%0d_last", i), 32'(out_last), 32'(vecs[i].e_last));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_in_ready));
      chk($sformatf("v%0d_cnt", i), 32'(byte_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_cnt_w", i), 32'(byte_cnt_w), 32'(vecs[i].e_cnt % 4));
    end
    in_valid = 1'b0;

    // Backpressure: DEPTH+1 bytes fill hold + FIFO, extra byte is refused
    for (int i = 0; i < 6; i++) bp[i] = 8'hC1 + 8'(i * 17);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = bp[i];
      step();
      chk($sformatf("bp_fill%0d_in_ready", i), 32'(in_ready), 32'(i < 4 ? 1 : 0));
    end
    in_data = bp[5];
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'(0));
      chk($sformatf("bp_hold%0d_out", i), 32'({out_valid, out_last, out_nib}),
          32'({1'b1, 1'b0, nib_of(bp[0], 1'b0)}));
    end
    in_valid = 1'b0;
    exp_bytes.delete();
    for (int i = 0; i < 5; i++) exp_bytes.push_back(bp[i]);
    drain("bp_drain");
    repeat (3) step();
    chk("bp_idle_valid", 32'(out_valid), 32'(0));
    chk("bp_in_ready", 32'(in_ready), 32'(1));
    chk("bp_cnt", 32'(byte_cnt), 32'(9));
    chk("bp_cnt_w", 32'(byte_cnt_w), 32'(1));

    // Counter wrap on the 2-bit instance
    do_reset();
    out_ready = 1'b1;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    prev_w = byte_cnt_w;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      step();
      in_valid = 1'b0;
      n_cnt = 0;
      while (byte_cnt_w == prev_w && n_cnt < 10) begin
        step();
        n_cnt++;
      end
      chk($sformatf("wrap%0d_cnt_w", i), 32'(byte_cnt_w), 32'(wrap_exp[i]));
      chk($sformatf("wrap%0d_cnt", i), 32'(byte_cnt), 32'(i + 1));
      prev_w = byte_cnt_w;
    end

    // Reset while the 0xA nibble of 0x5A is on the output
    repeat (2) step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    step();
    in_valid = 1'b0;
    n_cnt = 0;
    while (!out_valid && n_cnt < 5) begin
      step();
      n_cnt++;
    end
    if (out_nib != 4'hA && out_valid) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("rmid_pre", 32'({out_valid, out_nib}), 32'({1'b1, 4'hA}));
    #2 rst = 1'b1;
    #1;
    chk("rmid_valid", 32'(out_valid), 32'(0));
    chk("rmid_cnt", 32'(byte_cnt), 32'(0));
    chk("rmid_cnt_w", 32'(byte_cnt_w), 32'(0));
    chk("rmid_nib_last", 32'({out_last, out_nib}), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rmid_idle%0d", i), 32'({out_valid, in_ready}), 32'(2'b01));
    end
    // Fresh byte: visible two edges after the push edge
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("lat_n1", 32'(out_valid), 32'(0));
    step();
    chk("lat_n2", 32'({out_valid, out_last, out_nib}), 32'({1'b1, 1'b0, nib_of(8'h3C, 1'b0)}));
    step();
    chk("lat_hi", 32'({out_valid, out_last, out_nib}), 32'({1'b1, 1'b1, nib_of(8'h3C, 1'b1)}));
    step();
    chk("lat_done", 32'({out_valid, byte_cnt}), 32'({1'b0, 8'd1}));

    // Simultaneous push and pop with the FIFO half full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hD0 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("sim_occ0", 32'(dut.u_fifo.count_q), 32'(2));
    chk("sim_lo", 32'({out_valid, out_last, out_nib}), 32'({1'b1, 1'b0, nib_of(8'hD0, 1'b0)}));
    out_ready = 1'b1;
    step();
    chk("sim_hi", 32'({out_valid, out_last, out_nib}), 32'({1'b1, 1'b1, nib_of(8'hD0, 1'b1)}));
    chk("sim_occ1", 32'(dut.u_fifo.count_q), 32'(2));
    in_valid = 1'b1;
    in_data  = 8'hD3;
    step();
    in_valid = 1'b0;
    chk("sim_occ2", 32'(dut.u_fifo.count_q), 32'(2));
    exp_bytes.delete();
    exp_bytes.push_back(8'hD1);
    exp_bytes.push_back(8'hD2);
    exp_bytes.push_back(8'hD3);
    drain("sim_drain");
    repeat (2) step();
    chk("sim_end", 32'({out_valid, byte_cnt}), 32'({1'b0, 8'd5}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
